// File: rtl/axi_test_pkg.sv
// Shared types and constants for the AXI test sequencer: FSM states,
// AXI response codes and the burst-size/burst-count derivation.
package axi_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_DRAIN,
    RD,
    RD_DRAIN
  } seq_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int unsigned burst_bytes(input int unsigned beat_bytes,
                                              input int unsigned burst_len);
    return beat_bytes * (burst_len + 1);
  endfunction

  function automatic int unsigned num_bursts(input int unsigned region_bytes,
                                             input int unsigned beat_bytes,
                                             input int unsigned burst_len);
    return region_bytes / burst_bytes(beat_bytes, burst_len);
  endfunction

endpackage

// File: rtl/axi_burst_issuer.sv
// Address-channel burst issuer: walks NB bursts from BASE_ADDR, limits
// outstanding bursts to MAX_OUT and counts completion responses.
module axi_burst_issuer
  import axi_test_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int unsigned        BURST_BYTES = 16384,
  parameter int unsigned        NB          = 1,
  parameter int unsigned        MAX_OUT     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              active,
  input  logic              ready,
  input  logic              resp,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic              all_issued,
  output logic              all_done
);

  localparam logic [3:0]  MAX_C  = 4'(MAX_OUT);
  localparam logic [31:0] NB_C   = 32'(NB);
  localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(BURST_BYTES);

  logic [31:0] issued_cnt;
  logic [31:0] done_cnt;
  logic [3:0]  out_cnt;
  logic        hs;
  logic        dec;

  assign all_issued = (issued_cnt == NB_C);
  assign all_done   = (done_cnt == NB_C);
  // Valid depends only on registered state, so it cannot drop before ready.
  assign valid      = active && !all_issued && (out_cnt < MAX_C);
  assign hs         = valid && ready;
  // A response with nothing outstanding (misbehaving slave) must not underflow.
  assign dec        = resp && (out_cnt != 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= BASE_ADDR;
      issued_cnt <= '0;
      done_cnt   <= '0;
      out_cnt    <= '0;
    end else begin
      if (clear) begin
        addr       <= BASE_ADDR;
        issued_cnt <= '0;
        done_cnt   <= '0;
      end else begin
        if (hs) begin
          addr       <= addr + STEP_C;
          issued_cnt <= issued_cnt + 32'd1;
        end
        if (resp) done_cnt <= done_cnt + 32'd1;
      end
      if (hs && !dec)      out_cnt <= out_cnt + 4'd1;
      else if (!hs && dec) out_cnt <= out_cnt - 4'd1;
    end
  end

endmodule

// File: rtl/axi_test_sequencer.sv
// AXI memory test sequencer: writes the whole region in bursts, reads it
// back with identical addresses, counts passes and error responses.
module axi_test_sequencer
  import axi_test_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int unsigned       REGION_BYTES = 32'h1000_0000,
  parameter int unsigned       BEAT_BYTES   = 64,
  parameter logic [7:0]        BURST_LEN    = 8'd255,
  parameter int unsigned       MAX_OUT      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              loop_en,
  input  logic              stop,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic              WVALID,
  output logic              WLAST,
  input  logic              WREADY,
  input  logic              BVALID,
  input  logic [1:0]        BRESP,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic              RVALID,
  input  logic              RLAST,
  input  logic [1:0]        RRESP,
  output logic              RREADY,
  output logic              busy,
  output logic              pass_done,
  output logic [31:0]       pass_cnt,
  output logic [15:0]       resp_err_cnt
);

  localparam int unsigned BB = burst_bytes(BEAT_BYTES, 32'(BURST_LEN));
  localparam int unsigned NB = num_bursts(REGION_BYTES, BEAT_BYTES, 32'(BURST_LEN));

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  seq_state_t state_q, state_d;
  logic       wr_clear, rd_clear, pass_end, stop_lat;
  logic       wr_all_issued, wr_all_done, rd_all_issued, rd_all_done;
  logic       aw_hs, w_hs, w_last_hs, b_hs, r_last_hs, b_err, r_err;
  logic [1:0] err_inc;
  logic [4:0] w_pend;
  logic [7:0] w_beat;
  logic [15:0] err_cnt;

  assign busy         = (state_q != IDLE);
  assign BREADY       = busy;
  assign RREADY       = busy;
  assign AWLEN        = BURST_LEN;
  assign ARLEN        = BURST_LEN;
  assign resp_err_cnt = err_cnt;

  assign aw_hs     = AWVALID && AWREADY;
  assign b_hs      = BVALID && BREADY;
  assign r_last_hs = RVALID && RREADY && RLAST;
  // W beats only flow for bursts whose address has already been accepted.
  assign WVALID    = (w_pend != 5'd0);
  assign WLAST     = WVALID && (w_beat == BURST_LEN);
  assign w_hs      = WVALID && WREADY;
  assign w_last_hs = w_hs && WLAST;

  assign b_err   = b_hs && (BRESP != RESP_OKAY);
  assign r_err   = RVALID && RREADY && (RRESP != RESP_OKAY);
  assign err_inc = {1'b0, b_err} + {1'b0, r_err};

  axi_burst_issuer #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .BURST_BYTES(BB), .NB(NB), .MAX_OUT(MAX_OUT)
  ) u_aw (
    .clk(clk), .reset(reset), .clear(wr_clear), .active(state_q == WR),
    .ready(AWREADY), .resp(b_hs), .valid(AWVALID), .addr(AWADDR),
    .all_issued(wr_all_issued), .all_done(wr_all_done)
  );

  axi_burst_issuer #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .BURST_BYTES(BB), .NB(NB), .MAX_OUT(MAX_OUT)
  ) u_ar (
    .clk(clk), .reset(reset), .clear(rd_clear), .active(state_q == RD),
    .ready(ARREADY), .resp(r_last_hs), .valid(ARVALID), .addr(ARADDR),
    .all_issued(rd_all_issued), .all_done(rd_all_done)
  );

  always_comb begin
    state_d  = state_q;
    wr_clear = 1'b0;
    rd_clear = 1'b0;
    pass_end = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = WR;
        wr_clear = 1'b1;
      end
      WR: if (wr_all_issued) state_d = WR_DRAIN;
      WR_DRAIN: if (wr_all_done && (w_pend == 5'd0)) begin
        state_d  = RD;
        rd_clear = 1'b1;
      end
      RD: if (rd_all_issued) state_d = RD_DRAIN;
      RD_DRAIN: if (rd_all_done) begin
        pass_end = 1'b1;
        if (loop_en && !stop_lat && !stop) begin
          state_d  = WR;
          wr_clear = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      w_pend    <= '0;
      w_beat    <= '0;
      stop_lat  <= 1'b0;
      pass_done <= 1'b0;
      pass_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      pass_done <= pass_end;
      if (pass_end) pass_cnt <= pass_cnt + 32'd1;
      if (state_d == IDLE)   stop_lat <= 1'b0;
      else if (stop && busy) stop_lat <= 1'b1;
      if (aw_hs && !w_last_hs)      w_pend <= w_pend + 5'd1;
      else if (!aw_hs && w_last_hs) w_pend <= w_pend - 5'd1;
      if (w_hs) w_beat <= WLAST ? 8'd0 : w_beat + 8'd1;
      err_cnt <= sat_add16(err_cnt, err_inc);
    end
  end

endmodule

// File: tb/tb_axi_test_sequencer.sv
// Scoreboard bench for axi_test_sequencer with a small AXI slave model.
`timescale 1ns/1ps
module tb_axi_test_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, loop_en = 1'b0, stop = 1'b0;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RLAST, RREADY;
  logic [1:0]  BRESP, RRESP;
  logic        busy, pass_done;
  logic [31:0] pass_cnt;
  logic [15:0] resp_err_cnt;

  axi_test_sequencer #(
    .ADDR_W(32), .BASE_ADDR(32'h0), .REGION_BYTES(1024), .BEAT_BYTES(64),
    .BURST_LEN(8'd3), .MAX_OUT(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .loop_en(loop_en), .stop(stop),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RLAST(RLAST), .RRESP(RRESP), .RREADY(RREADY),
    .busy(busy), .pass_done(pass_done), .pass_cnt(pass_cnt), .resp_err_cnt(resp_err_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] cnt;
    logic [15:0] err;
  } pass_exp_t;

  logic [31:0] exp_aw[$];
  logic [31:0] exp_ar[$];
  logic        exp_wlast[$];
  pass_exp_t   exp_pass[$];

  int checks = 0;
  int errors = 0;

  // slave model state
  logic aw_rdy = 1'b1, b_en = 1'b1, inj = 1'b0, spur = 1'b0;
  int   b_pend = 0, r_beats = 0, r_idx = 0, w_allow = 0, wr_outstanding = 0;
  int   aw_hs_total = 0, passes_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected handshake, got 1 expected 0", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pass(input logic [31:0] cnt, input logic [15:0] err);
    pass_exp_t e;
    for (int k = 0; k < 4; k++) begin
      exp_aw.push_back(32'(k * 256));
      exp_ar.push_back(32'(k * 256));
    end
    for (int i = 0; i < 16; i++) exp_wlast.push_back((i % 4) == 3);
    e.cnt = cnt;
    e.err = err;
    exp_pass.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_passes(input int target, input string name);
    int n = 0;
    while (passes_seen < target && n < 2000) begin
      tick(1);
      n++;
    end
    if (passes_seen < target) check(name, 32'(passes_seen), 32'(target));
  endtask

  // AXI slave: decide handshakes mid-cycle, update drives just after the edge
  initial begin
    logic awh, wlh, bh, arh, rh, rs;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0; BRESP = 2'd0;
    ARREADY = 1'b1; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'd0;
    forever begin
      @(negedge clk);
      rs  = reset;
      awh = AWVALID && AWREADY;
      wlh = WVALID && WREADY && WLAST;
      bh  = BVALID && BREADY;
      arh = ARVALID && ARREADY;
      rh  = RVALID && RREADY;
      @(posedge clk);
      #1;
      if (rs) begin
        b_pend = 0; r_beats = 0; r_idx = 0; w_allow = 0; wr_outstanding = 0;
      end else begin
        if (awh) begin w_allow++; wr_outstanding++; end
        if (wlh) begin w_allow--; b_pend++; end
        if (bh && !spur) begin b_pend--; wr_outstanding--; end
        if (arh) r_beats += 4;
        if (rh) begin r_beats--; r_idx = (r_idx + 1) % 4; end
      end
      AWREADY = aw_rdy;
      BVALID  = b_en && (b_pend > 0);
      BRESP   = 2'd0;
      spur    = 1'b0;
      RVALID  = (r_beats > 0);
      RLAST   = RVALID && (r_idx == 3);
      RRESP   = 2'd0;
      if (inj && RVALID) begin
        RRESP = 2'd3;
        BRESP = 2'd2;
        if (!BVALID) begin BVALID = 1'b1; spur = 1'b1; end
        inj = 1'b0;
      end
    end
  end

  // monitor: pop expectations whenever the DUT completes a transfer
  initial begin
    pass_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (AWVALID && AWREADY) begin
          aw_hs_total++;
          check("aw_outstanding_below_max", 32'(wr_outstanding < 2), 32'd1);
          if (exp_aw.size() == 0) unexp("aw_extra");
          else begin
            check("awaddr", AWADDR, exp_aw.pop_front());
            check("awlen", 32'(AWLEN), 32'd3);
          end
        end
        if (ARVALID && ARREADY) begin
          if (exp_ar.size() == 0) unexp("ar_extra");
          else begin
            check("araddr", ARADDR, exp_ar.pop_front());
            check("arlen", 32'(ARLEN), 32'd3);
          end
        end
        if (WVALID && WREADY) begin
          check("w_after_aw", 32'(w_allow > 0), 32'd1);
          if (exp_wlast.size() == 0) unexp("w_extra");
          else check("wlast", 32'(WLAST), 32'(exp_wlast.pop_front()));
        end
        if (pass_done) begin
          passes_seen++;
          if (exp_pass.size() == 0) unexp("pass_done_extra");
          else begin
            e = exp_pass.pop_front();
            check("pass_cnt", pass_cnt, e.cnt);
            check("resp_err_cnt", 32'(resp_err_cnt), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    tick(3);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_awvalid", 32'(AWVALID), 0);
    check("rst_arvalid", 32'(ARVALID), 0);
    check("rst_wvalid", 32'(WVALID), 0);
    check("rst_readys", 32'({BREADY, RREADY}), 0);
    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_err_cnt", 32'(resp_err_cnt), 0);
    check("rst_awaddr", AWADDR, 0);
    check("rst_araddr", ARADDR, 0);

    // plain pass, all readys high
    push_pass(1, 16'h0);
    pulse_start();
    check("busy_running", 32'(busy), 1);
    check("bready_running", 32'(BREADY), 1);
    wait_passes(1, "pass1_timeout");
    tick(2);
    check("idle_after_pass1", 32'(busy), 0);

    // AWREADY held low for 5 cycles
    aw_rdy = 1'b0;
    push_pass(2, 16'h0);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      check("stall_awvalid", 32'(AWVALID), 1);
      check("stall_awaddr", AWADDR, 0);
      check("stall_no_w", 32'(WVALID), 0);
      tick(1);
    end
    aw_rdy = 1'b1;
    wait_passes(2, "pass2_timeout");
    tick(2);

    // B withheld: outstanding limit
    b_en = 1'b0;
    base = aw_hs_total;
    push_pass(3, 16'h0);
    pulse_start();
    tick(30);
    check("bhold_aw_count", 32'(aw_hs_total - base), 2);
    check("bhold_awvalid", 32'(AWVALID), 0);
    b_en = 1'b1;
    wait_passes(3, "pass3_timeout");
    tick(2);

    // simultaneous B and R error
    inj = 1'b1;
    push_pass(4, 16'd2);
    pulse_start();
    wait_passes(4, "pass4_timeout");
    tick(2);

    // saturation from a preset near the top
    @(negedge clk);
    dut.err_cnt = 16'hFFFE;
    tick(1);
    inj = 1'b1;
    push_pass(5, 16'hFFFF);
    pulse_start();
    wait_passes(5, "pass5_timeout");
    tick(2);

    // looping with stop during pass 2 read phase
    loop_en = 1'b1;
    push_pass(6, 16'hFFFF);
    push_pass(7, 16'hFFFF);
    pulse_start();
    wait_passes(6, "loop1_timeout");
    n = 0;
    while (!ARVALID && n < 500) begin tick(1); n++; end
    check("loop_reached_rd", 32'(ARVALID), 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_passes(7, "loop2_timeout");
    tick(6);
    check("stop_idle_busy", 32'(busy), 0);
    check("stop_pass_cnt", pass_cnt, 7);
    check("stop_no_aw", 32'(AWVALID), 0);
    loop_en = 1'b0;

    // reset mid-WR with two bursts outstanding
    b_en = 1'b0;
    exp_aw.push_back(32'd0);
    exp_aw.push_back(32'd256);
    for (int i = 0; i < 8; i++) exp_wlast.push_back((i % 4) == 3);
    pulse_start();
    n = 0;
    while (wr_outstanding < 2 && n < 100) begin tick(1); n++; end
    check("midwr_outstanding", 32'(wr_outstanding), 2);
    reset = 1'b1;
    tick(1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valids", 32'({AWVALID, WVALID, ARVALID}), 0);
    check("midrst_readys", 32'({BREADY, RREADY}), 0);
    check("midrst_pass_cnt", pass_cnt, 0);
    check("midrst_err_cnt", 32'(resp_err_cnt), 0);
    check("midrst_awaddr", AWADDR, 0);
    reset = 1'b0;
    exp_aw.delete();
    exp_wlast.delete();
    b_en = 1'b1;
    tick(2);
    base = passes_seen;
    push_pass(1, 16'h0);
    pulse_start();
    wait_passes(base + 1, "postrst_timeout");
    tick(2);
    check("postrst_busy", 32'(busy), 0);

    check("aw_queue_drained", 32'(exp_aw.size()), 0);
    check("ar_queue_drained", 32'(exp_ar.size()), 0);
    check("w_queue_drained", 32'(exp_wlast.size()), 0);
    check("pass_queue_drained", 32'(exp_pass.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
